multibyte_add_seq: RTL and testbench

- Byte-serial controller that adds or subtracts two NBYTES-wide operands by sequencing them one byte per clock through the existing 8-bit ripple-carry adder.
- Sits directly upstream of the adder: it drives the adder's a/b/ci inputs and consumes its sum/c outputs (combinational, same cycle).
- The carry is chained between bytes in a register.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.

---
 rtl/multibyte_add_seq.sv | 105 ++++++++++
 tb/tb_multibyte_add_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_seq.sv
// Byte-serial add/subtract controller: sequences two NBYTES-wide operands one byte per clock
// through an external 8-bit ripple-carry adder, chaining the carry in a register.
module multibyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_sub,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_ci,
    input  logic [7:0]          add_sum,
    input  logic                add_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_carry,
    output logic                out_ovf
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B up front, seed the carry with 1.
                        a_reg <= in_a;
                        b_reg <= in_b ^ {W{in_sub}};
                        carry <= in_sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[{idx, 3'b000} +: 8] <= add_sum;
                    carry                   <= add_c;
                    if (idx == LAST) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so there is no loop through the external adder.
    always_comb begin
        in_ready  = (state == IDLE);
        add_a     = 8'h00;
        add_b     = 8'h00;
        add_ci    = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_carry = 1'b0;
        out_ovf   = 1'b0;
        if (state == RUN) begin
            add_a  = a_reg[{idx, 3'b000} +: 8];
            add_b  = b_reg[{idx, 3'b000} +: 8];
            add_ci = carry;
        end
        if (state == DONE) begin
            out_valid = 1'b1;
            out_sum   = res;
            out_carry = carry;
            out_ovf   = (a_reg[W-1] == b_reg[W-1]) && (res[W-1] != a_reg[W-1]);
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: behavioural arithmetic model, directed cases,
// backpressure, mid-run reset and randomized traffic through a modelled 8-bit adder.
module tb_multibyte_add_seq;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_ci;
    logic [7:0]   add_sum;
    logic         add_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;

    int tests;
    int fails;

    logic [W-1:0] exp_sum;
    logic         exp_c;
    logic         exp_ovf;
    logic         have_exp;
    logic [W-1:0] last_sum;
    logic         last_c;
    logic         last_ovf;

    multibyte_add_seq #(
        .NBYTES(NBYTES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ci   (add_ci),
        .add_sum  (add_sum),
        .add_c    (add_c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_ovf  (out_ovf)
    );

    // External 8-bit ripple-carry adder.
    logic [8:0] adder_full;
    assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};
    assign add_sum    = adder_full[7:0];
    assign add_c      = adder_full[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Returns {ovf, carry, sum} from plain W-bit arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s    = full[W-1:0];
            c    = full[W];
            v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {v, c, s};
    endfunction

    // Result must match the model on every cycle it is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid && have_exp) begin
            chk("out_sum", 64'(out_sum), 64'(exp_sum));
            chk("out_carry", 64'(out_carry), 64'(exp_c));
            chk("out_ovf", 64'(out_ovf), 64'(exp_ovf));
            chk("in_ready_in_done", 64'(in_ready), 64'(0));
        end
    end

    task automatic set_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W+1:0] m;
        m        = model(a, b, sub);
        exp_sum  = m[W-1:0];
        exp_c    = m[W];
        exp_ovf  = m[W+1];
        have_exp = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'(1));
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        set_exp(a, b, sub);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("add_a_first", 64'(add_a), 64'(a[7:0]));
        chk("add_ci_first", 64'(add_ci), 64'(sub));
    endtask

    // Called one step after the accepting edge.
    task automatic wait_result(input int hold);
        out_ready = 1'($urandom_range(0, 1));
        repeat (NBYTES - 1) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("latency_early", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("latency", 64'(out_valid), 64'(1));
        last_sum = out_sum;
        last_c   = out_carry;
        last_ovf = out_ovf;
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_sum_stable", 64'(out_sum), 64'(last_sum));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'(0));
        chk("release_ready", 64'(in_ready), 64'(1));
        chk("idle_add_a", 64'(add_a), 64'(0));
        chk("idle_add_ci", 64'(add_ci), 64'(0));
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [W-1:0] esum, input logic ec,
                            input logic eovf);
        logic [W+1:0] m;
        m = model(a, b, sub);
        chk({name, "_model"}, 64'(m), 64'({eovf, ec, esum}));
        send(a, b, sub);
        wait_result(0);
        chk({name, "_sum"}, 64'(last_sum), 64'(esum));
        chk({name, "_carry"}, 64'(last_c), 64'(ec));
        chk({name, "_ovf"}, 64'(last_ovf), 64'(eovf));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W - 1) {1'b0}}};
            3:       return {1'b0, {(W - 1) {1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        tests     = 0;
        fails     = 0;
        have_exp  = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_add_b", 64'(add_b), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("carry8", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("noborrow", 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        directed("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("ovf_sub", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure with a new request pending on the input.
        send(32'h0000_1234, 32'h0000_0F0F, 1'b0);
        repeat (NBYTES - 1) @(posedge clk);
        @(posedge clk);
        #1;
        chk("bp_valid", 64'(out_valid), 64'(1));
        last_sum = out_sum;
        in_a     = 32'hDEAD_0000;
        in_b     = 32'h0000_BEEF;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_stable", 64'(out_sum), 64'(last_sum));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_valid", 64'(out_valid), 64'(0));
        chk("bp_idle_ready", 64'(in_ready), 64'(1));
        set_exp(32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept", 64'(in_ready), 64'(0));
        wait_result(0);
        chk("bp_second_sum", 64'(last_sum), 64'(32'hDEAD_BEEF));

        // Reset during the second RUN cycle.
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_in_ready", 64'(in_ready), 64'(1));
        chk("mrst_add", 64'({add_a, add_b, add_ci}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (NBYTES + 1) begin
            @(posedge clk);
            #1;
            chk("mrst_stays_idle", 64'(out_valid), 64'(0));
        end
        directed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = pick();
            rb = pick();
            send(ra, rb, 1'($urandom_range(0, 1)));
            wait_result(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
